// File: rtl/servo_ramp_if.sv
// rtl/servo_ramp_if.sv - register bus bundle for the servo ramp block
interface servo_ramp_if;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;

    modport master (output din, output address, output w_en, output r_en, input dout);
    modport slave  (input din, input address, input w_en, input r_en, output dout);
endinterface

// File: rtl/servo_ramp.sv
// rtl/servo_ramp.sv - memory-mapped slew-rate limiter feeding a servo PWM controller
module servo_ramp #(
    parameter logic [7:0]  SERVO_RAMP_ADDRESS = 8'h00,
    parameter int unsigned CLK_FREQ           = 16000000,
    parameter int unsigned TICK_HZ            = 1000,
    parameter logic [7:0]  INIT_POS           = 8'd128
) (
    input  logic            clk,
    input  logic            rst,
    servo_ramp_if.slave     bus,
    output logic [7:0]      servo_pos,
    output logic            servo_wr,
    output logic            done_irq
);
    localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, MOVING} state_t;

    state_t           state_q, state_d;
    logic [7:0]       pos_q, pos_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       rate_q, rate_d;
    logic [7:0]       rate_cnt_q, rate_cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             done_q, done_d;
    logic [7:0]       dout_q, dout_d;
    logic             servo_wr_q, servo_wr_d;
    logic             done_irq_q, done_irq_d;

    logic [8:0] off9;
    logic       in_range, wr_target, wr_rate, rd_status, tick, done_set;
    logic [7:0] tgt, step_pos;

    always_comb begin
        off9      = {1'b0, bus.address} - {1'b0, SERVO_RAMP_ADDRESS};
        in_range  = off9 < 9'd4;
        wr_target = bus.w_en && in_range && (off9[1:0] == 2'd0);
        wr_rate   = bus.w_en && in_range && (off9[1:0] == 2'd1);
        rd_status = bus.r_en && in_range && (off9[1:0] == 2'd2);
        tick      = (pre_q == PRE_W'(TICK_DIV - 1));

        pre_d      = tick ? '0 : pre_q + 1'b1;
        state_d    = state_q;
        pos_d      = pos_q;
        target_d   = target_q;
        rate_d     = wr_rate ? bus.din : rate_q;
        rate_cnt_d = rate_cnt_q;
        servo_wr_d = 1'b0;
        done_set   = 1'b0;
        // A TARGET write in the same cycle as a tick steers that tick toward the new target.
        tgt        = wr_target ? bus.din : target_q;
        step_pos   = (tgt > pos_q) ? pos_q + 8'd1 : pos_q - 8'd1;

        case (state_q)
            IDLE: begin
                if (wr_target) begin
                    target_d = bus.din;
                    if (bus.din != pos_q) begin
                        if (rate_q == 8'd0) begin
                            pos_d      = bus.din;
                            servo_wr_d = 1'b1;
                            done_set   = 1'b1;
                        end else begin
                            rate_cnt_d = 8'd0;
                            state_d    = MOVING;
                        end
                    end
                end
            end
            MOVING: begin
                target_d = tgt;
                if (wr_target && (bus.din == pos_q)) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end else if (rate_q == 8'd0) begin
                    pos_d      = tgt;
                    servo_wr_d = 1'b1;
                    done_set   = 1'b1;
                    state_d    = IDLE;
                end else if (tick) begin
                    // >= so that lowering RATE below the running count steps on the next tick.
                    if (rate_cnt_q >= rate_q - 8'd1) begin
                        rate_cnt_d = 8'd0;
                        pos_d      = step_pos;
                        servo_wr_d = 1'b1;
                        if (step_pos == tgt) begin
                            state_d  = IDLE;
                            done_set = 1'b1;
                        end
                    end else begin
                        rate_cnt_d = rate_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        done_irq_d = done_set;
        done_d     = done_q;
        if (rd_status) done_d = 1'b0;
        if (done_set)  done_d = 1'b1;

        dout_d = dout_q;
        if (!in_range) begin
            dout_d = 8'd0;
        end else if (bus.r_en) begin
            case (off9[1:0])
                2'd0:    dout_d = target_q;
                2'd1:    dout_d = rate_q;
                2'd2:    dout_d = {6'd0, done_q, state_q == MOVING};
                default: dout_d = pos_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pos_q      <= INIT_POS;
            target_q   <= INIT_POS;
            rate_q     <= 8'd0;
            rate_cnt_q <= 8'd0;
            pre_q      <= '0;
            done_q     <= 1'b0;
            dout_q     <= 8'd0;
            servo_wr_q <= 1'b0;
            done_irq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            target_q   <= target_d;
            rate_q     <= rate_d;
            rate_cnt_q <= rate_cnt_d;
            pre_q      <= pre_d;
            done_q     <= done_d;
            dout_q     <= dout_d;
            servo_wr_q <= servo_wr_d;
            done_irq_q <= done_irq_d;
        end
    end

    assign servo_pos = pos_q;
    assign servo_wr  = servo_wr_q;
    assign done_irq  = done_irq_q;
    assign bus.dout  = dout_q;
endmodule

// File: tb/tb_servo_ramp.sv
// tb/tb_servo_ramp.sv - scoreboard bench for servo_ramp strobes and register reads
module tb_servo_ramp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    servo_ramp_if bus();
    logic [7:0] servo_pos;
    logic       servo_wr, done_irq;

    servo_ramp #(
        .SERVO_RAMP_ADDRESS(8'h00),
        .CLK_FREQ(16000),
        .TICK_HZ(1000),
        .INIT_POS(8'd128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .servo_pos(servo_pos),
        .servo_wr(servo_wr),
        .done_irq(done_irq)
    );

    typedef struct {
        logic [7:0] pos;
        logic       irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   strobe_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   wr_cnt   = 0;
    int   irq_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (servo_wr) begin
                strobe_cyc.push_back(cyc);
                wr_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL strobe_unexpected: got servo_pos=%0d, no strobe expected", servo_pos);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (servo_pos !== mon_e.pos || done_irq !== mon_e.irq) begin
                        n_fail++;
                        $display("FAIL strobe_value: got pos=%0d irq=%b, expected pos=%0d irq=%b",
                                 servo_pos, done_irq, mon_e.pos, mon_e.irq);
                    end
                end
            end
            if (done_irq) irq_cnt++;
        end
    end

    task automatic push(input logic [7:0] p, input logic irq);
        exp_t e;
        e.pos = p;
        e.irq = irq;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.address = a;
        bus.din     = d;
        bus.w_en    = 1'b1;
        @(negedge clk); #1;
        bus.w_en    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        bus.address = a;
        bus.r_en    = 1'b1;
        @(negedge clk); #1;
        bus.r_en    = 1'b0;
        d           = bus.dout;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d strobes still pending, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic jump_to(input logic [7:0] p);
        logic [7:0] s;
        wr(8'h01, 8'd0);
        push(p, 1'b1);
        wr(8'h00, p);
        drain(20, "jump");
        rd(8'h02, s);
    endtask

    task automatic test_reset;
        logic [7:0] s;
        logic [7:0] exp_regs [4];
        exp_regs[0] = 8'd128; exp_regs[1] = 8'd0; exp_regs[2] = 8'd0; exp_regs[3] = 8'd128;
        rst = 1'b0;
        idle(3);
        n_checks++;
        if (servo_pos !== 8'd128 || servo_wr !== 1'b0 || done_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pos=%0d wr=%b irq=%b, required 128/0/0", servo_pos, servo_wr, done_irq);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(8'(i), s);
            n_checks++;
            if (s !== exp_regs[i]) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %0d, required %0d", i, s, exp_regs[i]);
            end
        end
        idle(40);
        n_checks++;
        if (wr_cnt != 0 || irq_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: got wr=%0d irq=%0d, required 0/0", wr_cnt, irq_cnt);
        end
    endtask

    task automatic test_rate0;
        logic [7:0] s;
        int irq0 = irq_cnt;
        push(8'd200, 1'b1);
        wr(8'h00, 8'd200);
        drain(20, "rate0");
        idle(3);
        n_checks++;
        if (irq_cnt - irq0 != 1) begin
            n_fail++;
            $display("FAIL rate0_irq_count: got %0d, required 1", irq_cnt - irq0);
        end
        rd(8'h02, s);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL rate0_status1: got %h, required 02", s); end
        rd(8'h02, s);
        n_checks++;
        if (s !== 8'h00) begin n_fail++; $display("FAIL rate0_status2: got %h, required 00", s); end
        rd(8'h03, s);
        n_checks++;
        if (s !== 8'd200) begin n_fail++; $display("FAIL rate0_position: got %0d, required 200", s); end
    endtask

    task automatic test_ramp;
        logic [7:0] s;
        int base, busy_bad, n;
        jump_to(8'd128);
        wr(8'h01, 8'd2);
        push(8'd129, 1'b0);
        push(8'd130, 1'b0);
        push(8'd131, 1'b1);
        base = strobe_cyc.size();
        wr(8'h00, 8'd131);
        busy_bad = 0;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            rd(8'h02, s);
            if (s[0] !== 1'b1) busy_bad++;
            n++;
        end
        drain(10, "ramp");
        n_checks++;
        if (busy_bad != 0) begin n_fail++; $display("FAIL ramp_busy: got %0d not-busy reads, required 0", busy_bad); end
        n_checks++;
        if (strobe_cyc.size() - base != 3) begin
            n_fail++;
            $display("FAIL ramp_count: got %0d strobes, required 3", strobe_cyc.size() - base);
        end else begin
            n_checks++;
            if (strobe_cyc[base+1] - strobe_cyc[base] != 32 || strobe_cyc[base+2] - strobe_cyc[base+1] != 32) begin
                n_fail++;
                $display("FAIL ramp_spacing: got %0d,%0d cycles, required 32,32",
                         strobe_cyc[base+1] - strobe_cyc[base], strobe_cyc[base+2] - strobe_cyc[base+1]);
            end
        end
        rd(8'h02, s);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL ramp_status_done: got %h, required 02", s); end
    endtask

    task automatic test_bounds;
        logic [7:0] s;
        jump_to(8'd10);
        wr(8'h01, 8'd1);
        for (int p = 9; p >= 0; p--) push(8'(p), p == 0);
        wr(8'h00, 8'd0);
        drain(400, "down_to_0");
        idle(40);
        rd(8'h03, s);
        n_checks++;
        if (s !== 8'd0) begin n_fail++; $display("FAIL bound_low: got %0d, required 0", s); end
        for (int p = 1; p <= 255; p++) push(8'(p), p == 255);
        wr(8'h00, 8'd255);
        drain(4400, "up_to_255");
        idle(40);
        rd(8'h03, s);
        n_checks++;
        if (s !== 8'd255) begin n_fail++; $display("FAIL bound_high: got %0d, required 255", s); end
        rd(8'h02, s);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL bound_status: got %h, required 02", s); end
    endtask

    task automatic test_retarget;
        logic [7:0] s;
        jump_to(8'd100);
        wr(8'h01, 8'd1);
        for (int p = 101; p <= 105; p++) push(8'(p), 1'b0);
        wr(8'h00, 8'd150);
        drain(200, "retarget_up");
        for (int p = 104; p >= 90; p--) push(8'(p), p == 90);
        wr(8'h00, 8'd90);
        drain(400, "retarget_down");
        idle(40);
        rd(8'h03, s);
        n_checks++;
        if (s !== 8'd90) begin n_fail++; $display("FAIL retarget_position: got %0d, required 90", s); end
        rd(8'h02, s);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL retarget_status: got %h, required 02", s); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] s;
        int wr0;
        jump_to(8'd138);
        wr(8'h01, 8'd1);
        push(8'd139, 1'b0);
        push(8'd140, 1'b0);
        wr(8'h00, 8'd160);
        drain(100, "mid_ramp");
        rst = 1'b0;
        idle(1);
        n_checks++;
        if (servo_pos !== 8'd128 || servo_wr !== 1'b0 || done_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got pos=%0d wr=%b irq=%b, required 128/0/0", servo_pos, servo_wr, done_irq);
        end
        rst = 1'b1;
        wr0 = wr_cnt;
        idle(100);
        n_checks++;
        if (wr_cnt != wr0) begin n_fail++; $display("FAIL midreset_quiet: got %0d strobes, required 0", wr_cnt - wr0); end
        rd(8'h02, s);
        n_checks++;
        if (s !== 8'h00) begin n_fail++; $display("FAIL midreset_status: got %h, required 00", s); end
        rd(8'h03, s);
        n_checks++;
        if (s !== 8'd128) begin n_fail++; $display("FAIL midreset_position: got %0d, required 128", s); end
    endtask

    initial begin
        bus.din     = 8'd0;
        bus.address = 8'd0;
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        @(negedge clk); #1;
        test_reset();
        test_rate0();
        test_ramp();
        test_bounds();
        test_retarget();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
